// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default parameters for the FIFO write-side arbiter.
package fifo_wr_arbiter_pkg;

  localparam int NREQ_DEFAULT      = 4;
  localparam int WIDTH_DEFAULT     = 8;
  localparam int MAX_BEATS_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester beat bus plus FIFO write port. The master drives requests and FIFO status.
// The slave is the arbiter.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wfull;
  logic                  fifo_winc;
  logic [WIDTH-1:0]      fifo_wdata;

  modport master (
    output req_valid, req_last, req_data, fifo_wfull,
    input  req_ready, fifo_winc, fifo_wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_wfull,
    output req_ready, fifo_winc, fifo_wdata
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Rotating-priority picker: the first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arb_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int idx;

  // NOTE: every output and temporary gets a default before the loop, so no latch can be inferred.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter in front of a sync FIFO write port.
// An owner keeps the port until its last beat is accepted.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEFAULT,
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic [IDW-1:0]      grant_id,
  output logic                locked,
  output logic                overlong,
  input  logic                overlong_clr
);

  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

  state_e         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  beat_cnt;

  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [IDW-1:0] g;
  logic           sel_valid;
  logic           accept;
  logic           beat_last;
  logic [IDW-1:0] g_next;
  logic [CW-1:0]  next_cnt;
  logic           long_hit;

  rr_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // In LOCKED the owner is the only candidate; other requesters are ignored.
  assign g         = (state == ST_LOCKED) ? owner : pick_idx;
  assign sel_valid = (state == ST_LOCKED) ? bus.req_valid[owner] : pick_any;
  assign accept    = rst_n & sel_valid & ~bus.fifo_wfull;
  assign beat_last = bus.req_last[g];
  assign g_next    = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;

  // Packet length including this beat, saturating so it never wraps back under the limit.
  assign next_cnt = (state == ST_IDLE)  ? CW'(1)   :
                    (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + 1'b1;
  assign long_hit = accept && (next_cnt > CW'(MAX_BEATS));

  assign bus.fifo_winc  = accept;
  assign bus.fifo_wdata = accept ? bus.req_data[int'(g)*WIDTH +: WIDTH] : '0;
  assign bus.req_ready  = accept ? (NREQ'(1) << g) : '0;

  assign grant_id = owner;
  assign locked   = (state == ST_LOCKED);

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      overlong <= 1'b0;
    end else begin
      if (accept) begin
        owner <= g;
        if (beat_last) begin
          state    <= ST_IDLE;
          rr_ptr   <= g_next;
          beat_cnt <= '0;
        end else begin
          state    <= ST_LOCKED;
          beat_cnt <= next_cnt;
        end
      end

      if (long_hit) begin
        overlong <= 1'b1;
      end else if (overlong_clr) begin
        overlong <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locking write arbiter that shares one sync FIFO write port between NREQ requesters.
- Each requester uses a valid/ready/last beat interface. The arbiter drives the FIFO's winc/wdata and observes its wfull.
- It sits directly in front of the FIFO write side. The FIFO read side is untouched.
- Once a requester wins, it owns the port until its last beat is accepted, so packets never interleave in the FIFO.

Parameters:
- NREQ, 4, number of requesters; must be >= 2.
- WIDTH, 8, data width; must equal the FIFO WIDTH.
- MAX_BEATS, 16, packet length above which the overlong flag is raised.
- IDW, $clog2(NREQ), requester index width (derived, not overridable).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of packet.
- req_data  input  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  per-requester beat accepted this cycle.
- fifo_wfull  input  1  FIFO full.
- fifo_winc  output  1  FIFO write strobe.
- fifo_wdata  output  WIDTH  FIFO write data.
- grant_id  output  IDW  index of the current or last owner.
- locked  output  1  high while a multi-beat packet holds the port.
- overlong  output  1  sticky: a packet exceeded MAX_BEATS beats.
- overlong_clr  input  1  synchronous clear of overlong.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, owner/grant_id 0, beat_cnt 0, overlong 0, locked 0.
- Reset asserted mid-packet abandons the packet. No FIFO write occurs while rst_n is low.
- Beat acceptance: accept = req_valid[g] & ~fifo_wfull, where g is the granted index.
- Outputs on an accepted beat, combinational and in the same cycle:
  - fifo_winc = accept.
  - fifo_wdata = req_data slice g.
  - req_ready = onehot(g) & accept.
  - Zero-latency pass-through; the FIFO captures the beat on that clock edge.
- Non-granted requesters: req_ready stays 0.
- When no beat is accepted: fifo_winc = 0 and fifo_wdata = 0.
- Protocol rule: requesters must not make valid depend on ready. Valid, data and last hold until accepted.
- State IDLE (locked = 0):
  - g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - No valid requester: nothing happens.
  - Accepted beat with last = 1: stay IDLE; rr_ptr <= (g+1) mod NREQ; grant_id <= g.
  - Accepted beat with last = 0: go to LOCKED; owner <= g; grant_id <= g; beat_cnt <= 1.
  - fifo_wfull = 1: no acceptance, and state and rr_ptr are unchanged. The pick is re-evaluated each cycle.
- State LOCKED (locked = 1):
  - g = owner; all other valids are ignored.
  - Each accepted beat increments beat_cnt, saturating at MAX_BEATS+1.
  - Accepted beat with last = 1: go to IDLE; rr_ptr <= (owner+1) mod NREQ; beat_cnt <= 0.
  - wfull or an owner bubble (valid = 0): hold the state; no timeout.
- Overlong flag:
  - Set when an accepted beat makes the packet length greater than MAX_BEATS.
  - Packet length counts the first beat.
  - The lock is not broken when the flag sets.
  - overlong_clr clears it; set wins over a simultaneous clear.
- Fairness: after serving requester k, requester k has the lowest priority. Worst-case wait is NREQ-1 packets.

Decomposition:
- Shared package/header holds:
  - State encodings ST_IDLE = 1'b0, ST_LOCKED = 1'b1.
  - Default parameter constants.
- Sub-module rr_arb_pick: purely combinational rotating priority picker.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: gnt_idx[IDW], any.
- The top level holds the FSM, rr_ptr, owner, beat_cnt, overlong and the datapath mux.

Test Plan:
- Single-beat round-robin:
  - Stimulus: all 4 valid with last = 1, data 8'hA0+i, wfull = 0.
  - Response: fifo_wdata sequence A0, A1, A2, A3, A0 on 5 consecutive cycles with fifo_winc = 1; grant_id 0, 1, 2, 3, 0.
- Packet lock:
  - Stimulus: req1 sends a 3-beat packet 11, 12, 13 while req0 and req2 are valid with single beats.
  - Response: FIFO gets 11, 12, 13 back-to-back with locked = 1 for 2 cycles, then req2's beat (rr_ptr = 2).
- Backpressure:
  - Stimulus: fifo_wfull = 1 for 3 cycles mid-packet.
  - Response: fifo_winc = 0 and req_ready = 0 during those cycles; owner held; the packet resumes intact with no duplicated or lost beat.
- Overlong:
  - Stimulus: MAX_BEATS = 4, req3 sends 6 beats.
  - Response: overlong rises on the 5th accepted beat; all 6 beats are written; lock is released after beat 6. overlong_clr then clears it, with set winning when coincident.
- Reset mid-packet:
  - Stimulus: rst_n pulsed low after beat 2 of a 4-beat packet from req2.
  - Response: locked = 0, grant_id = 0, rr_ptr = 0 immediately. The next arbitration starts at requester 0.
- Idle / no request:
  - Stimulus: all valids 0.
  - Response: fifo_winc = 0, fifo_wdata = 0, state unchanged over 10 cycles.
